// File: rtl/hazard_pkg.sv
// hazard_pkg -- shared definitions for the pipeline hazard controller.
//   hz_state_t  : controller FSM states (RUN, MEM_WAIT, REDIRECT)
//   MEM_TIMEOUT : consecutive MEM_WAIT cycles that raise timeout_err
//   hz_ctrl_t   : bundle of the six pipeline stall/flush controls, plus the
//                 handful of control patterns the controller ever produces.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } hz_state_t;

  localparam logic [7:0] MEM_TIMEOUT = 8'd255;

  typedef struct packed {
    logic stall_pc;
    logic stall_if_id;
    logic stall_id_ex;
    logic stall_ex_mem;
    logic flush_if_id;
    logic flush_id_ex;
  } hz_ctrl_t;

  // Pattern order: {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
  //                 flush_if_id, flush_id_ex}
  localparam hz_ctrl_t CTRL_NONE       = 6'b0000_00;
  localparam hz_ctrl_t CTRL_FREEZE     = 6'b1111_00;  // data-memory stall
  localparam hz_ctrl_t CTRL_FLUSH_ALL  = 6'b0000_11;  // redirect / reset
  localparam hz_ctrl_t CTRL_LOAD_USE   = 6'b1100_01;  // hold IF/ID, bubble EX
  localparam hz_ctrl_t CTRL_FETCH_WAIT = 6'b1000_10;  // hold PC, bubble ID

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect -- combinational load-use hazard detector.
//   id_rs1/id_rs2         : source registers of the IF/ID instruction
//   id_use_rs1/id_use_rs2 : that source is actually read
//   ex_rd, ex_mem_read    : destination of the ID/EX instruction, it is a load
//   load_use              : the IF/ID instruction needs the load result now
// Register x0 is hard-wired zero, so a load targeting it never conflicts.
module hazard_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use
);

  logic [4:0] src_reg [2];
  logic [1:0] src_use;
  logic [1:0] src_hit;

  assign src_reg[0] = id_rs1;
  assign src_reg[1] = id_rs2;
  assign src_use    = {id_use_rs2, id_use_rs1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_use[gi] && (src_reg[gi] == ex_rd);
    end
  endgenerate

  assign load_use = ex_mem_read && (ex_rd != 5'd0) && (|src_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller (stall / flush generation).
//   Inputs : clk, rst (sync, active-high), IF/ID source regs and use flags,
//            ID/EX destination and load flag, ex_branch_taken, imem_ready,
//            dmem_req, dmem_ready.
//   Outputs: stall_pc, stall_if_id, stall_id_ex, stall_ex_mem (hold regs),
//            flush_if_id, flush_id_ex (load bubble), timeout_err (sticky).
//   Optional: define HAZARD_PERF_EN to add 32-bit wrapping counters
//            stall_cycles (cycles with stall_pc) and flush_events (cycles
//            with flush_id_ex).
// Priority: reset > data-memory stall > REDIRECT fetch wait > branch >
// load-use > instruction fetch wait.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        stall_id_ex,
  output logic        stall_ex_mem,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        timeout_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  hz_state_t  state_reg, state_next;
  hz_ctrl_t   ctrl;
  logic [7:0] wait_cnt_reg;
  logic       timeout_err_reg;
  logic       load_use;
  logic       dmem_stall;

  hazard_detect u_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  assign dmem_stall = dmem_req && !dmem_ready;

  always_comb begin
    state_next = state_reg;
    ctrl       = CTRL_NONE;
    if (rst) begin
      // Reset fills the front of the pipe with bubbles whatever the state.
      ctrl       = CTRL_FLUSH_ALL;
      state_next = RUN;
    end else if (dmem_stall) begin
      // Freeze everything; a pending redirect is remembered, not lost.
      ctrl       = CTRL_FREEZE;
      state_next = (state_reg == REDIRECT) ? REDIRECT : MEM_WAIT;
    end else begin
      case (state_reg)
        REDIRECT: begin
          if (imem_ready) begin
            state_next = RUN;
          end else begin
            ctrl = CTRL_FETCH_WAIT;
          end
        end
        default: begin
          // RUN, and MEM_WAIT on the cycle the access completes.
          state_next = RUN;
          if (ex_branch_taken) begin
            ctrl = CTRL_FLUSH_ALL;
            if (!imem_ready) begin
              state_next = REDIRECT;
            end
          end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
          end else if (!imem_ready) begin
            ctrl = CTRL_FETCH_WAIT;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      wait_cnt_reg    <= 8'd0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == MEM_WAIT && state_next == MEM_WAIT) begin
        // Saturate so the counter cannot wrap back below the threshold.
        if (wait_cnt_reg != MEM_TIMEOUT) begin
          wait_cnt_reg <= wait_cnt_reg + 8'd1;
        end
        if (wait_cnt_reg == MEM_TIMEOUT - 8'd1) begin
          timeout_err_reg <= 1'b1;
        end
      end else begin
        wait_cnt_reg <= 8'd0;
      end
    end
  end

  assign stall_pc     = ctrl.stall_pc;
  assign stall_if_id  = ctrl.stall_if_id;
  assign stall_id_ex  = ctrl.stall_id_ex;
  assign stall_ex_mem = ctrl.stall_ex_mem;
  assign flush_if_id  = ctrl.flush_if_id;
  assign flush_id_ex  = ctrl.flush_id_ex;
  assign timeout_err  = timeout_err_reg;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_reg;
  logic [31:0] flush_events_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_reg <= 32'd0;
      flush_events_reg <= 32'd0;
    end else begin
      if (ctrl.stall_pc) begin
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      end
      if (ctrl.flush_id_ex) begin
        flush_events_reg <= flush_events_reg + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign flush_events = flush_events_reg;
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single system clock, all state on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: id_rs1, id_rs2  in  5 each  source registers of the instruction held in IF/ID.
REQ-004 SHALL have ports: id_use_rs1, id_use_rs2  in  1 each  the instruction reads that source.
REQ-005 SHALL have ports: ex_rd  in  5  destination of the ID/EX instruction; ex_mem_read  in  1  that instruction is a load.
REQ-006 SHALL have port: ex_branch_taken  in  1  taken branch or jump resolved in EX.
REQ-007 SHALL have ports: imem_ready  in  1  fetch data valid; dmem_req  in  1  MEM-stage access pending; dmem_ready  in  1  access completes this cycle.
REQ-008 SHALL have ports: stall_pc, stall_if_id, stall_id_ex, stall_ex_mem  out  1 each  hold the register.
REQ-009 SHALL have ports: flush_if_id, flush_id_ex  out  1 each  load a bubble (NOP, err cleared).
REQ-010 SHALL have port: timeout_err  out  1  sticky data-memory timeout.
REQ-011 SHALL have ports, under HAZARD_PERF_EN only: stall_cycles, flush_events  out  32 each.

Function
REQ-012 SHALL implement FSM states RUN, MEM_WAIT, REDIRECT; outputs combinational from state and inputs.
REQ-013 SHALL treat dmem_req & !dmem_ready ("dmem stall") as highest priority: all four stall outputs 1, both flushes 0, in every state.
REQ-014 SHALL, in RUN on dmem stall, move to MEM_WAIT; in REDIRECT on dmem stall, stay REDIRECT.
REQ-015 SHALL, absent dmem stall, on ex_branch_taken: flush_if_id=1, flush_id_ex=1, stalls 0; next state REDIRECT if imem_ready=0, else RUN.
REQ-016 SHALL detect load-use as ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)); when no dmem stall or branch: stall_pc=1, stall_if_id=1, flush_id_ex=1 for exactly that cycle.
REQ-017 SHALL, absent the above, on imem_ready=0: stall_pc=1, flush_if_id=1; otherwise all outputs 0.
REQ-018 SHALL, in MEM_WAIT with dmem_ready=1, apply REQ-015..017 in that same cycle and return to RUN.
REQ-019 SHALL, in REDIRECT, hold stall_pc=1, flush_if_id=1 until imem_ready=1, then return to RUN with all outputs 0 that cycle.
REQ-020 SHALL count consecutive MEM_WAIT cycles in an 8-bit counter, cleared on leaving MEM_WAIT; on reaching MEM_TIMEOUT set timeout_err until reset; FSM remains in MEM_WAIT.
REQ-021 SHALL keep x0 exempt: ex_rd==0 never produces load-use.

Reset
REQ-022 SHALL, on rst sampled high, enter RUN, clear wait counter, timeout_err, and perf counters.
REQ-023 SHALL, while rst high, drive all stalls 0, flush_if_id=1, flush_id_ex=1, regardless of state.
REQ-024 SHALL abandon MEM_WAIT/REDIRECT on reset mid-operation with no residual stall after rst falls.

Configuration
REQ-025 SHALL, with HAZARD_PERF_EN defined, increment stall_cycles each cycle stall_pc=1 and flush_events each cycle flush_id_ex=1, 32-bit wrapping.
REQ-026 SHALL, without HAZARD_PERF_EN, omit both ports and counters; all other behaviour identical.

Structure
REQ-027 SHALL place the state enum and MEM_TIMEOUT (255) in shared package hazard_pkg.
REQ-028 SHALL implement load-use compare in sub-module hazard_detect (combinational); FSM and counters in hazard_ctrl.

Verification
REQ-029 Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> stall_pc=stall_if_id=flush_id_ex=1 one cycle; ex_rd=0 variant -> no stall.
REQ-030 Branch with imem_ready=0 for 3 cycles -> flush_if_id=flush_id_ex=1 cycle 0, REDIRECT with stall_pc=flush_if_id=1 cycles 1-3, RUN on cycle imem_ready=1.
REQ-031 dmem_req=1, dmem_ready=0 for 4 cycles plus simultaneous ex_branch_taken -> full freeze 4 cycles, branch flush applied on dmem_ready cycle.
REQ-032 dmem_ready held 0 for 300 cycles -> timeout_err rises after 255 MEM_WAIT cycles, stays 1 until rst.
REQ-033 rst asserted in MEM_WAIT -> flushes 1 during rst, RUN with all outputs 0 first cycle after.
REQ-034 HAZARD_PERF_EN build: 3 load-use + 1 branch -> stall_cycles=3, flush_events=4.
